// File: rtl/sysid_verifier.sv
// sysid_verifier: boot-time identity checker for the system-ID Avalon-MM slave.
// After reset, and on each start request in DONE, it reads word 0 (ID) and
// word 1 (timestamp), compares both against build-time parameters and
// publishes registered pass/fail status.
//
// Ports:
//   clock, reset       single rising-edge clock, synchronous active-high reset
//   start              one-cycle rerun request, honoured only in DONE
//   av_address/av_read Avalon-MM read command to the system-ID slave
//   av_waitrequest     command stall from slave/fabric
//   av_readdatavalid   read response strobe, with av_readdata (32 bits)
//   busy, done         check in progress / last check finished
//   id_ok, ts_ok       captured words matched EXPECTED_ID / EXPECTED_TS
//   timeout_err        last check aborted by the watchdog
//   sys_id, sys_ts     captured word 0 / word 1
//
// Optional feature: define SYSID_VERIFIER_TIMEOUT_EN to build the per-read
// watchdog (TIMEOUT_CYCLES, 1..65535). Without it the FSM waits indefinitely
// and timeout_err stays 0.
module sysid_verifier #(
   parameter logic [31:0] EXPECTED_ID    = 32'd11,
   parameter logic [31:0] EXPECTED_TS    = 32'd1448617297,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        av_address,
   output logic        av_read,
   input  logic        av_waitrequest,
   input  logic        av_readdatavalid,
   input  logic [31:0] av_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] sys_id,
   output logic [31:0] sys_ts
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state, state_d;
   logic        av_address_d, av_read_d, busy_d, done_d;
   logic        id_ok_d, ts_ok_d, timeout_d;
   logic [31:0] sys_id_d, sys_ts_d;
   logic        accept, capture, expire;

   // av_read is registered and high only in the REQ states, so it doubles as
   // the "command outstanding" qualifier.
   assign accept = av_read & ~av_waitrequest;

   // A response counts only after the command has been accepted (same cycle
   // for a zero-latency fabric); strobes elsewhere are ignored.
   always_comb begin
      capture = 1'b0;
      case (state)
         ID_REQ, TS_REQ:   capture = accept & av_readdatavalid;
         ID_WAIT, TS_WAIT: capture = av_readdatavalid;
         default:          capture = 1'b0;
      endcase
   end

`ifdef SYSID_VERIFIER_TIMEOUT_EN
   localparam int unsigned WDOG_W = 16;

   logic [WDOG_W-1:0] wdog, wdog_d;

   // Counter value counts cycles already spent in this read, so the
   // TIMEOUT_CYCLES-th cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign expire = busy & (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

   // Restart on entry to each REQ state, count every REQ/WAIT cycle.
   always_comb begin
      wdog_d = wdog;
      if ((state_d == ID_REQ || state_d == TS_REQ) && state_d != state) begin
         wdog_d = '0;
      end else if (busy) begin
         wdog_d = wdog + WDOG_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wdog <= '0;
      end else begin
         wdog <= wdog_d;
      end
   end
`else
   logic unused_timeout;

   assign expire         = 1'b0;
   assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state;
      sys_id_d  = sys_id;
      sys_ts_d  = sys_ts;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;

      case (state)
         IDLE: state_d = ID_REQ;

         ID_REQ, ID_WAIT: begin
            if (capture) begin
               sys_id_d = av_readdata;
               state_d  = TS_REQ;
            end else if (expire) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else if (state == ID_REQ && accept) begin
               state_d = ID_WAIT;
            end
         end

         TS_REQ, TS_WAIT: begin
            if (capture) begin
               sys_ts_d = av_readdata;
               state_d  = DONE;
               id_ok_d  = (sys_id == EXPECTED_ID);
               ts_ok_d  = (av_readdata == EXPECTED_TS);
            end else if (expire) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else if (state == TS_REQ && accept) begin
               state_d = TS_WAIT;
            end
         end

         DONE: begin
            if (start) begin
               state_d = ID_REQ;
            end else begin
               id_ok_d   = id_ok;
               ts_ok_d   = ts_ok;
               timeout_d = timeout_err;
            end
         end

         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      av_read_d    = (state_d == ID_REQ) || (state_d == TS_REQ);
      av_address_d = (state_d == TS_REQ);
      busy_d       = (state_d != IDLE) && (state_d != DONE);
      done_d       = (state_d == DONE);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Output and capture registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         av_address  <= 1'b0;
         av_read     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         sys_id      <= '0;
         sys_ts      <= '0;
      end else begin
         av_address  <= av_address_d;
         av_read     <= av_read_d;
         busy        <= busy_d;
         done        <= done_d;
         id_ok       <= id_ok_d;
         ts_ok       <= ts_ok_d;
         timeout_err <= timeout_d;
         sys_id      <= sys_id_d;
         sys_ts      <= sys_ts_d;
      end
   end

endmodule

// File: tb/tb_sysid_verifier.sv
// Bench for sysid_verifier: a behavioural Avalon-MM slave with configurable
// stall and response latency, and a reference model that predicts the done
// cycle and status from those settings.
module tb_sysid_verifier;

   localparam logic [31:0] EXP_ID = 32'd11;
   localparam logic [31:0] EXP_TS = 32'd1448617297;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        av_address;
   logic        av_read;
   logic        av_waitrequest;
   logic        av_readdatavalid;
   logic [31:0] av_readdata;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout_err;
   logic [31:0] sys_id;
   logic [31:0] sys_ts;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Slave configuration and state, indexed by word address.
   int          w_cfg [2];
   int          l_cfg [2];
   logic [31:0] word  [2];
   int          stall_cnt   = 0;
   bit          pend_active = 1'b0;
   int          pend_due    = 0;
   logic        pend_addr   = 1'b0;
   bit          prev_wr     = 1'b0;
   logic        prev_addr   = 1'b0;
   bit          inject_spur = 1'b0;

   always #5 clock = ~clock;

   sysid_verifier #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .av_address      (av_address),
      .av_read         (av_read),
      .av_waitrequest  (av_waitrequest),
      .av_readdatavalid(av_readdatavalid),
      .av_readdata     (av_readdata),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout_err     (timeout_err),
      .sys_id          (sys_id),
      .sys_ts          (sys_ts)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk1({tag, "_av_read"}, av_read, 1'b0);
      chk1({tag, "_av_address"}, av_address, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_id_ok"}, id_ok, 1'b0);
      chk1({tag, "_ts_ok"}, ts_ok, 1'b0);
      chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
      chk32({tag, "_sys_id"}, sys_id, 32'd0);
      chk32({tag, "_sys_ts"}, sys_ts, 32'd0);
   endtask

   // Advance to the middle of the next cycle, then play the slave for it.
   task automatic at_neg();
      logic a;
      @(negedge clock);
      cyc++;
      start            = 1'b0;
      av_waitrequest   = 1'b0;
      av_readdatavalid = 1'b0;
      av_readdata      = $urandom;
      if (reset) begin
         pend_active = 1'b0;
         stall_cnt   = 0;
         prev_wr     = 1'b0;
      end else begin
         if (prev_wr) begin
            chk1("stall_av_read", av_read, 1'b1);
            chk1("stall_av_address", av_address, prev_addr);
         end
         if (pend_active && pend_due == cyc) begin
            av_readdatavalid = 1'b1;
            av_readdata      = word[pend_addr];
            pend_active      = 1'b0;
         end
         if (av_read) begin
            a = av_address;
            if (stall_cnt < w_cfg[a]) begin
               av_waitrequest = 1'b1;
               stall_cnt++;
            end else begin
               stall_cnt = 0;
               if (l_cfg[a] == 0) begin
                  av_readdatavalid = 1'b1;
                  av_readdata      = word[a];
               end else begin
                  pend_active = 1'b1;
                  pend_due    = cyc + l_cfg[a];
                  pend_addr   = a;
               end
            end
         end
         if (inject_spur && done) begin
            av_readdatavalid = 1'b1;
            av_readdata      = $urandom;
         end
         prev_wr   = av_waitrequest;
         prev_addr = av_address;
      end
   endtask

   task automatic set_slave(input int w0, input int w1, input int l0, input int l1,
                            input logic [31:0] idw, input logic [31:0] tsw);
      w_cfg[0] = w0;
      w_cfg[1] = w1;
      l_cfg[0] = l0;
      l_cfg[1] = l1;
      word[0]  = idw;
      word[1]  = tsw;
   endtask

   // Launch one check this cycle (start pulse or reset release) and follow it.
   // Model: cycle 0 is the launch cycle; a zero-stall, one-cycle-latency read
   // pair finishes at cycle 5, each stall or extra latency cycle adds one,
   // a zero-latency response saves one.
   task automatic run_check(input int w0, input int w1, input int l0, input int l1,
                            input logic [31:0] idw, input logic [31:0] tsw,
                            input bit via_start, input bit busy_start);
      int t0;
      int td;
      set_slave(w0, w1, l0, l1, idw, tsw);
      if (via_start) start = 1'b1;
      else reset = 1'b0;
      t0 = cyc;
      td = t0 + 5 + w0 + w1 + (l0 - 1) + (l1 - 1);
      while (cyc < td + 2) begin
         at_neg();
         if (busy_start && cyc == t0 + 2) start = 1'b1;
         chk1("busy", busy, cyc < td);
         chk1("done", done, cyc >= td);
         if (cyc >= td) begin
            chk32("sys_id", sys_id, idw);
            chk32("sys_ts", sys_ts, tsw);
            chk1("id_ok", id_ok, idw == EXP_ID);
            chk1("ts_ok", ts_ok, tsw == EXP_TS);
            chk1("timeout_err", timeout_err, 1'b0);
            chk1("done_av_read", av_read, 1'b0);
         end
      end
   endtask

   initial begin
      int t0;
      reset            = 1'b1;
      start            = 1'b0;
      av_waitrequest   = 1'b0;
      av_readdatavalid = 1'b0;
      av_readdata      = '0;
      set_slave(0, 0, 1, 1, EXP_ID, EXP_TS);

      repeat (3) at_neg();
      chk_rst("por");

      // Nominal slave, auto-start after reset release.
      run_check(0, 0, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);

      // Wrong ID word.
      run_check(0, 0, 1, 1, 32'd12, EXP_TS, 1'b1, 1'b0);

      // Zero-latency responses, spurious valid in DONE, start while busy.
      inject_spur = 1'b1;
      run_check(0, 0, 0, 0, EXP_ID, EXP_TS, 1'b1, 1'b1);
      inject_spur = 1'b0;

`ifndef SYSID_VERIFIER_TIMEOUT_EN
      // Three stall cycles on each read.
      run_check(3, 3, 1, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);

      // Randomized stall, latency and data.
      for (int i = 0; i < 10; i++) begin
         int          rw0, rw1, rl0, rl1;
         logic [31:0] rid, rts;
         rw0 = $urandom_range(0, 3);
         rw1 = $urandom_range(0, 3);
         rl0 = $urandom_range(0, 3);
         rl1 = $urandom_range(0, 3);
         rid = ($urandom_range(0, 1) == 0) ? EXP_ID : 32'($urandom);
         rts = ($urandom_range(0, 1) == 0) ? EXP_TS : 32'($urandom);
         run_check(rw0, rw1, rl0, rl1, rid, rts, 1'b1, 1'b0);
      end
`endif

      // Reset during TS_WAIT, then a full check after release.
      set_slave(0, 0, 1, 3, 32'h1234_5678, 32'h9abc_def0);
      start = 1'b1;
      t0    = cyc;
      while (cyc < t0 + 4) at_neg();
      chk1("ts_wait_busy", busy, 1'b1);
      chk1("ts_wait_av_read", av_read, 1'b0);
      reset = 1'b1;
      at_neg();
      chk_rst("mid_reset");
      at_neg();
      run_check(0, 0, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);

`ifdef SYSID_VERIFIER_TIMEOUT_EN
      // No response to the ID read: watchdog aborts four cycles into ID_REQ.
      set_slave(0, 0, 1000, 1, EXP_ID, EXP_TS);
      start = 1'b1;
      t0    = cyc;
      while (cyc < t0 + 4) begin
         at_neg();
         chk1("tmo_busy", busy, 1'b1);
      end
      at_neg();
      chk1("tmo_timeout_err", timeout_err, 1'b1);
      chk1("tmo_done", done, 1'b1);
      chk1("tmo_av_read", av_read, 1'b0);
      chk1("tmo_id_ok", id_ok, 1'b0);
      chk1("tmo_ts_ok", ts_ok, 1'b0);
      chk1("tmo_busy_end", busy, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
